tank_access_sequencer: RTL and testbench
========================================

// Module: tank_access_sequencer
// PURPOSE
//  Schedules and times accesses to the mercury-tank store on behalf of two
//  requesters: operand access (read/write) and order fetch (read only).
//  Tracks circulation position (word/digit) from the digit-pulse strobe.
//  Selects the tank and holds read/write enables for exactly one word time,
//  aligned to the addressed word. Drives the tank decoders' read/write/select inputs.
// PARAMETERS
//  DIGITS     18  digit periods per word (minor cycle), >=2
//  WORD_BITS  5   word-position address bits; words per tank = 2**WORD_BITS
//  TANK_BITS  5   tank-number address bits
// PORTS
//  clk        in   1          system clock
//  cls_neg    in   1          async active-low reset
//  dp         in   1          digit-pulse strobe, 1 clk wide, >=2 clks apart
//  op_req     in   1          operand request, level, held until op_ack
//  op_we      in   1          1=write, 0=read; sampled with op_req at grant
//  op_addr    in   TANK_BITS+WORD_BITS  {tank,word}; sampled at grant
//  op_ack     out  1          1-clk pulse, operand transfer complete
//  fe_req     in   1          fetch request, level, held until fe_ack
//  fe_addr    in   TANK_BITS+WORD_BITS  {tank,word}; sampled at grant
//  fe_ack     out  1          1-clk pulse, fetch transfer complete
//  tank_sel   out  TANK_BITS  selected tank, valid while busy
//  mem_read   out  1          read enable, one word time
//  mem_write  out  1          write enable, one word time
//  word_pos   out  WORD_BITS  current circulating word number
//  busy       out  1          1 in any state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, word/digit counters 0, last_op 0.
//  Position: digit_ctr +1 on dp; at DIGITS-1 wraps to 0 and word_ctr +1 (mod 2**WORD_BITS).
//   Counters run in every state; word_pos = word_ctr.
//  FSM (all outputs registered):
//   IDLE: if op_req|fe_req, grant one, latch addr/we/tank_sel -> WAIT.
//    Both requesting: operand wins unless last_op=1 (previous grant was operand),
//    then fetch wins. last_op updated at each grant. Fetch grant forces we=0.
//   WAIT: on clk with dp=1, digit_ctr=DIGITS-1, word_ctr=target-1 (mod) -> XFER.
//    Counters become {target,0} on same edge. Entering WAIT at/after
//    that strobe waits a full revolution (2**WORD_BITS words).
//   XFER: mem_read=~we, mem_write=we for whole state; exits on dp with
//    digit_ctr=DIGITS-1 -> DONE. Duration exactly DIGITS dp intervals.
//   DONE: mem_read/mem_write 0; pulse op_ack or fe_ack (granted one) -> IDLE.
//  Latency: req -> grant 1 clk; worst case wait = one revolution + one word.
//  Back-to-back: new grant earliest clk after DONE; a request for the next
//   word therefore misses it and waits a full revolution (defined behaviour).
//  Requester dropping req after grant: ignored; transfer completes, ack still issued.
//  Address/we changes after grant: ignored until next grant.
//  dp during DONE/IDLE: counters advance normally.
//  cls_neg low mid-transfer: immediate return to reset state; no ack.
// TESTING (DIGITS=18, WORD_BITS=5, TANK_BITS=5)
//  1 Reset, dp every 4 clk, op_req we=0 addr={3,5} at word 0 -> mem_read high
//    exactly 18 dp while word_pos=5, tank_sel=3, op_ack 1 clk after.
//  2 op_req we=1 addr={7,9} issued at word 9 digit 4 -> waits to word 9 of
//    next revolution; mem_write 18 dp long; mem_read stays 0.
//  3 op_req and fe_req same clk, repeated: grants op,fe,op,fe; acks alternate.
//  4 fe_req addr={2,31} -> transfer during word 31, counters wrap to word 0
//    at XFER end; fe_ack issued; mem_write never asserted.
//  5 cls_neg low during XFER -> mem_read/busy 0 asynchronously, counters 0,
//    no ack; after release new request served normally.
//  6 op_req dropped in WAIT -> transfer still occurs, op_ack pulses once.

Source files
------------

// File: rtl/tank_access_sequencer.sv
// tank_access_sequencer: arbitrates operand/fetch requests and times each tank access to the addressed circulating word
module tank_access_sequencer #(
  parameter int DIGITS    = 18,
  parameter int WORD_BITS = 5,
  parameter int TANK_BITS = 5
) (
  input  logic                           clk_i,
  input  logic                           cls_neg_i,
  input  logic                           dp_i,
  input  logic                           op_req_i,
  input  logic                           op_we_i,
  input  logic [TANK_BITS+WORD_BITS-1:0] op_addr_i,
  output logic                           op_ack_o,
  input  logic                           fe_req_i,
  input  logic [TANK_BITS+WORD_BITS-1:0] fe_addr_i,
  output logic                           fe_ack_o,
  output logic [TANK_BITS-1:0]           tank_sel_o,
  output logic                           mem_read_o,
  output logic                           mem_write_o,
  output logic [WORD_BITS-1:0]           word_pos_o,
  output logic                           busy_o
);
  localparam int DW = (DIGITS > 2) ? $clog2(DIGITS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;
  state_t               state_q, state_d;
  logic [DW-1:0]        digit_q, digit_d;
  logic [WORD_BITS-1:0] word_q, word_d, tgt_q, tgt_d;
  logic [TANK_BITS-1:0] tank_q, tank_d;
  logic                 we_q, we_d, last_op_q, last_op_d, own_op_q, own_op_d;
  logic                 rd_q, rd_d, wr_q, wr_d, op_ack_q, op_ack_d, fe_ack_q, fe_ack_d, busy_q, busy_d;
  logic                 word_end, grant_op, grant_fe;
  // circulation position: digit counter steps on each strobe, word counter steps at the last digit
  always_comb begin
    word_end = dp_i && digit_q == DW'(DIGITS - 1);
    digit_d  = !dp_i ? digit_q : word_end ? '0 : digit_q + 1'b1;
    word_d   = word_end ? word_q + 1'b1 : word_q;
  end
  // arbitration, word alignment and registered output decode
  always_comb begin
    grant_op  = op_req_i && !(fe_req_i && last_op_q);
    grant_fe  = fe_req_i && !grant_op;
    state_d   = state_q;
    tgt_d     = tgt_q;
    tank_d    = tank_q;
    we_d      = we_q;
    last_op_d = last_op_q;
    own_op_d  = own_op_q;
    case (state_q)
      IDLE: if (grant_op || grant_fe) begin
        state_d         = WAIT;
        own_op_d        = grant_op;
        last_op_d       = grant_op;
        {tank_d, tgt_d} = grant_op ? op_addr_i : fe_addr_i;
        we_d            = grant_op && op_we_i;
      end
      WAIT: if (word_end && word_q + 1'b1 == tgt_q) state_d = XFER;
      XFER: if (word_end) state_d = DONE;
      default: state_d = IDLE;
    endcase
    rd_d     = state_d == XFER && !we_q;
    wr_d     = state_d == XFER && we_q;
    op_ack_d = state_d == DONE && own_op_q;
    fe_ack_d = state_d == DONE && !own_op_q;
    busy_d   = state_d != IDLE;
  end
  // state, position and output registers
  always_ff @(posedge clk_i or negedge cls_neg_i) begin
    if (!cls_neg_i) begin
      state_q   <= IDLE;
      digit_q   <= '0;
      word_q    <= '0;
      tgt_q     <= '0;
      tank_q    <= '0;
      we_q      <= 1'b0;
      last_op_q <= 1'b0;
      own_op_q  <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      op_ack_q  <= 1'b0;
      fe_ack_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      digit_q   <= digit_d;
      word_q    <= word_d;
      tgt_q     <= tgt_d;
      tank_q    <= tank_d;
      we_q      <= we_d;
      last_op_q <= last_op_d;
      own_op_q  <= own_op_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      op_ack_q  <= op_ack_d;
      fe_ack_q  <= fe_ack_d;
      busy_q    <= busy_d;
    end
  end
  assign op_ack_o    = op_ack_q;
  assign fe_ack_o    = fe_ack_q;
  assign tank_sel_o  = tank_q;
  assign mem_read_o  = rd_q;
  assign mem_write_o = wr_q;
  assign word_pos_o  = word_q;
  assign busy_o      = busy_q;
endmodule

// File: tb/tb_tank_access_sequencer.sv
// tb_tank_access_sequencer: scoreboard bench for the tank access sequencer
module tb_tank_access_sequencer;
  logic       clk = 0, rst_n = 0, dp = 0, op_req = 0, op_we = 0, fe_req = 0;
  logic [9:0] op_addr = 0, fe_addr = 0;
  logic       op_ack, fe_ack, mem_read, mem_write, busy;
  logic [4:0] tank_sel, word_pos;
  int         n_cmp = 0, n_err = 0, dp_cnt = 0;
  typedef struct {logic is_op; logic [4:0] tank; logic [4:0] word; logic wr; int start;} exp_t;
  exp_t       q[$];
  exp_t       e;
  logic       in_x = 0, seen = 0, bad = 0, s_rd = 0, s_wr = 0;
  logic [4:0] s_tank = 0, s_word = 0;
  int         s_dp = 0, e_dp = 0;

  tank_access_sequencer dut (
    .clk_i(clk), .cls_neg_i(rst_n), .dp_i(dp),
    .op_req_i(op_req), .op_we_i(op_we), .op_addr_i(op_addr), .op_ack_o(op_ack),
    .fe_req_i(fe_req), .fe_addr_i(fe_addr), .fe_ack_o(fe_ack),
    .tank_sel_o(tank_sel), .mem_read_o(mem_read), .mem_write_o(mem_write),
    .word_pos_o(word_pos), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // one-clock digit strobe every four clocks
  initial forever begin
    repeat (3) @(negedge clk);
    dp = 1;
    @(negedge clk);
    dp = 0;
  end

  // number of strobes the design has accepted since reset
  always @(posedge clk or negedge rst_n)
    if (!rst_n) dp_cnt <= 0;
    else if (dp) dp_cnt <= dp_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_x(input logic is_op, input logic [4:0] tank, input logic [4:0] word,
                          input logic wr, input int start);
    q.push_back('{is_op, tank, word, wr, start});
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic wait_dp(input int n);
    int i;
    for (i = 0; i < 10000 && dp_cnt != n; i++) @(negedge clk);
    if (dp_cnt != n) chk("wait_dp_timeout", dp_cnt, n);
  endtask

  // hold requests as levels, dropping each one on the clock its ack is seen
  task automatic request(input logic o, input logic f, input logic we,
                         input logic [9:0] oa, input logic [9:0] fa);
    int i;
    @(negedge clk);
    op_req = o; op_we = we; op_addr = oa; fe_req = f; fe_addr = fa;
    for (i = 0; i < 6000 && (op_req || fe_req); i++) begin
      @(negedge clk);
      if (op_ack) op_req = 0;
      if (fe_ack) fe_req = 0;
    end
    if (op_req || fe_req) begin
      chk("request_timeout", {op_req, fe_req}, 0);
      op_req = 0;
      fe_req = 0;
    end
  endtask

  // monitor: captures each transfer window and scores it against the queue on the ack
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      in_x = 0;
      seen = 0;
    end else begin
      if (mem_read || mem_write) begin
        if (!in_x) begin
          in_x = 1; seen = 0; bad = 0; s_dp = dp_cnt;
          s_rd = mem_read; s_wr = mem_write; s_tank = tank_sel; s_word = word_pos;
        end else if (mem_read !== s_rd || mem_write !== s_wr || tank_sel !== s_tank || word_pos !== s_word)
          bad = 1;
      end else if (in_x) begin
        in_x = 0; seen = 1; e_dp = dp_cnt;
      end
      if (op_ack || fe_ack) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_ack: got op_ack=%0b fe_ack=%0b expected no ack", op_ack, fe_ack);
        end else begin
          e = q.pop_front();
          chk("ack_is_op", int'(op_ack), int'(e.is_op));
          chk("ack_single", int'(op_ack && fe_ack), 0);
          chk("xfer_seen", int'(seen), 1);
          chk("xfer_tank", int'(s_tank), int'(e.tank));
          chk("xfer_word", int'(s_word), int'(e.word));
          chk("xfer_write", int'(s_wr), int'(e.wr));
          chk("xfer_read", int'(s_rd), int'(!e.wr));
          chk("xfer_start_dp", s_dp, e.start);
          chk("xfer_len_dp", e_dp - s_dp, 18);
          chk("xfer_stable", int'(bad), 0);
          chk("word_after", int'(word_pos), int'(5'(e.word + 5'd1)));
          seen = 0;
        end
      end
    end
  end

  initial begin
    int i;
    #1;
    chk("rst_op_ack", int'(op_ack), 0);
    chk("rst_fe_ack", int'(fe_ack), 0);
    chk("rst_mem_read", int'(mem_read), 0);
    chk("rst_mem_write", int'(mem_write), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tank_sel", int'(tank_sel), 0);
    chk("rst_word_pos", int'(word_pos), 0);
    reset_dut();
    // read {3,5} from word 0
    expect_x(1, 5'd3, 5'd5, 0, 90);
    request(1, 0, 0, {5'd3, 5'd5}, '0);
    // write {7,9} granted at word 9 digit 4: waits a full revolution
    wait_dp(166);
    expect_x(1, 5'd7, 5'd9, 1, 738);
    request(1, 0, 1, {5'd7, 5'd9}, '0);
    // simultaneous requests alternate; fetch of the following word misses it
    reset_dut();
    expect_x(1, 5'd1, 5'd2, 0, 36);
    expect_x(0, 5'd4, 5'd3, 0, 630);
    request(1, 1, 0, {5'd1, 5'd2}, {5'd4, 5'd3});
    wait_dp(650);
    expect_x(1, 5'd5, 5'd10, 0, 756);
    expect_x(0, 5'd6, 5'd12, 0, 792);
    request(1, 1, 0, {5'd5, 5'd10}, {5'd6, 5'd12});
    // fetch of word 31 wraps the word counter; op_we must not leak into a fetch
    wait_dp(812);
    expect_x(0, 5'd2, 5'd31, 0, 1134);
    request(0, 1, 1, '0, {5'd2, 5'd31});
    // reset during a transfer: everything clears at once, no ack
    reset_dut();
    @(negedge clk);
    op_req = 1; op_we = 0; op_addr = {5'd9, 5'd1};
    for (i = 0; i < 2000 && !mem_read; i++) @(negedge clk);
    chk("abort_xfer_reached", int'(mem_read), 1);
    repeat (5) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_mem_read", int'(mem_read), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_word_pos", int'(word_pos), 0);
    chk("abort_tank_sel", int'(tank_sel), 0);
    chk("abort_op_ack", int'(op_ack), 0);
    op_req = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    expect_x(1, 5'd9, 5'd1, 0, 18);
    request(1, 0, 0, {5'd9, 5'd1}, '0);
    // request dropped while waiting: transfer and a single ack still happen
    wait_dp(40);
    expect_x(1, 5'd4, 5'd6, 1, 108);
    @(negedge clk);
    op_req = 1; op_we = 1; op_addr = {5'd4, 5'd6};
    for (i = 0; i < 100 && !busy; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    op_req = 0;
    chk("drop_busy", int'(busy), 1);
    for (i = 0; i < 3000 && !op_ack; i++) @(negedge clk);
    chk("drop_ack", int'(op_ack), 1);
    repeat (200) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
